shared_mem_rr: RTL

SHARED_MEM_RR -- requirements
Module: shared_mem_rr

---
 rtl/shared_mem_rr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/shared_mem_rr.sv
// Shared single-port scratchpad with a round-robin arbiter across COUNT cores.
// Optional grant locking is enabled by defining SHARED_MEM_LOCK_EN.
module shared_mem_rr #(
  parameter int unsigned COUNT    = 4,
  parameter int unsigned BUS_SIZE = 128,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned MAX_LOCK = 16,
  localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [COUNT-1:0]             i_req,
  input  logic [COUNT-1:0]             i_we,
  input  logic [COUNT*ADDR_W-1:0]      i_addr,
  input  logic [COUNT*BUS_SIZE-1:0]    i_data,
`ifdef SHARED_MEM_LOCK_EN
  input  logic [COUNT-1:0]             i_lock,
`endif
  output logic [BUS_SIZE-1:0]          o_data,
  output logic [COUNT-1:0]             o_grant,
  output logic [COUNT-1:0]             o_rvalid
);

  localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [IDX_W-1:0]    rr_idx, gnt_idx;
  logic [IDX_W:0]      cand;
  logic                rr_found, gnt_vld;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BUS_SIZE-1:0] sel_data;
  logic                sel_we, in_range;
  logic [BUS_SIZE-1:0] mem [DEPTH];

`ifdef SHARED_MEM_LOCK_EN
  localparam int unsigned LCNT_W = $clog2(MAX_LOCK + 1);
  logic              lock_vld, lock_vld_nxt, locked;
  logic [IDX_W-1:0]  lock_own, lock_own_nxt;
  logic [LCNT_W-1:0] lock_cnt, lock_cnt_nxt, cnt_inc;
`endif

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(COUNT - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  // Round-robin search starting at ptr, wrapping COUNT-1 -> 0
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 0; i < int'(COUNT); i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(COUNT)) cand = cand - (IDX_W+1)'(COUNT);
      if (!rr_found && i_req[cand[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Final grant: a live lock owner overrides round-robin
  always_comb begin
    gnt_vld = rr_found & i_rstn;
    gnt_idx = rr_idx;
`ifdef SHARED_MEM_LOCK_EN
    locked  = 1'b0;
    if (lock_vld && i_req[lock_own] && i_lock[lock_own]) begin
      gnt_idx = lock_own;
      locked  = 1'b1;
    end
`endif
    o_grant = '0;
    if (gnt_vld) o_grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    for (int k = 0; k < int'(COUNT); k++) begin
      if (gnt_idx == IDX_W'(k)) begin
        sel_addr = i_addr[k*ADDR_W +: ADDR_W];
        sel_data = i_data[k*BUS_SIZE +: BUS_SIZE];
        sel_we   = i_we[k];
      end
    end
    in_range = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
  end

  // Pointer and lock bookkeeping
  always_comb begin
    ptr_nxt = ptr;
    if (gnt_vld) ptr_nxt = inc_idx(gnt_idx);
`ifdef SHARED_MEM_LOCK_EN
    lock_vld_nxt = 1'b0;
    lock_own_nxt = lock_own;
    lock_cnt_nxt = '0;
    cnt_inc      = locked ? lock_cnt + LCNT_W'(1) : LCNT_W'(1);
    if (gnt_vld && i_lock[gnt_idx] && (cnt_inc < LCNT_W'(MAX_LOCK))) begin
      lock_vld_nxt = 1'b1;
      lock_own_nxt = gnt_idx;
      lock_cnt_nxt = cnt_inc;
      if (locked) ptr_nxt = ptr;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr      <= '0;
      o_rvalid <= '0;
      o_data   <= '0;
`ifdef SHARED_MEM_LOCK_EN
      lock_vld <= 1'b0;
      lock_own <= '0;
      lock_cnt <= '0;
`endif
    end else begin
      ptr      <= ptr_nxt;
      o_rvalid <= '0;
      if (gnt_vld && !sel_we) begin
        o_rvalid <= o_grant;
        o_data   <= in_range ? mem[sel_addr] : '0;
      end
`ifdef SHARED_MEM_LOCK_EN
      lock_vld <= lock_vld_nxt;
      lock_own <= lock_own_nxt;
      lock_cnt <= lock_cnt_nxt;
`endif
    end
  end

  // Scratchpad storage is intentionally not reset
  always_ff @(posedge i_clk) begin
    if (gnt_vld && sel_we && in_range) mem[sel_addr] <= sel_data;
  end

endmodule
